// File: rtl/pran_loader_pkg.sv
// Shared definitions for the UART boot loader: sync byte and state encodings
// for the loader FSM and the UART receiver.
package pran_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LD_SYNC,
    LD_LEN0,
    LD_LEN1,
    LD_DATA,
    LD_WRITE,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/pran_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect, mid-bit
// sampling. Emits a 1-cycle rx_valid with the byte, or frame_err on a bad stop bit.
module pran_uart_rx
  import pran_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT / 2 : 1;

  logic            r_meta;
  logic            r_sync;
  logic            r_prev;
  rx_state_t       r_state;
  rx_state_t       w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_fall;
  logic            w_half_tick;
  logic            w_bit_tick;

  assign w_fall      = r_prev & ~r_sync;
  assign w_half_tick = (r_cnt == CW'(HALF - 1));
  assign w_bit_tick  = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RX_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      // Still high at mid start bit means a glitch, not a frame.
      RX_START: if (w_half_tick) w_next = r_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_tick && (r_bit == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_bit_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_prev    <= 1'b1;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      r_meta    <= uart_rx;
      r_sync    <= r_meta;
      r_prev    <= r_sync;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
        RX_START: r_cnt <= w_half_tick ? '0 : r_cnt + CW'(1);
        RX_DATA: begin
          if (w_bit_tick) begin
            r_cnt   <= '0;
            r_shift <= {r_sync, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (w_bit_tick) begin
            r_cnt <= '0;
            if (r_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= r_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/pran_uart_loader.sv
// Boot loader: receives A5, 16-bit LE word count, then LE 32-bit words over UART,
// writes them to the CPU's external memory port and releases cpu_reset when done.
module pran_uart_loader
  import pran_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MAX_WORDS    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  logic        w_rx_valid;
  logic [7:0]  w_rx_byte;
  logic        w_frame_err;
  logic        w_is_sync;
  logic [15:0] w_len;
  ld_state_t   r_state;
  ld_state_t   w_next;
  logic [7:0]  r_len_lo;
  logic [15:0] r_words_left;
  logic [23:0] r_word;
  logic [1:0]  r_idx;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_err;

  pran_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_valid  (w_rx_valid),
    .rx_byte   (w_rx_byte),
    .frame_err (w_frame_err)
  );

  assign w_is_sync     = w_rx_valid && (w_rx_byte == SYNC_BYTE);
  assign w_len         = {w_rx_byte, r_len_lo};
  assign Ext_WriteData = r_wdata;
  assign Ext_DataAdr   = r_adr;
  assign load_done     = r_done;
  assign load_err      = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LD_SYNC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    cpu_reset    = 1'b1;
    Ext_MemWrite = 1'b0;
    case (r_state)
      LD_SYNC: if (w_is_sync) w_next = LD_LEN0;
      LD_LEN0: begin
        if (w_frame_err)     w_next = LD_ERR;
        else if (w_rx_valid) w_next = LD_LEN1;
      end
      LD_LEN1: begin
        if (w_frame_err) w_next = LD_ERR;
        else if (w_rx_valid) begin
          if (w_len == 16'd0)        w_next = LD_DONE;
          else if (w_len > MAX_LEN)  w_next = LD_ERR;
          else                       w_next = LD_DATA;
        end
      end
      LD_DATA: begin
        if (w_frame_err)                          w_next = LD_ERR;
        else if (w_rx_valid && (r_idx == 2'd3))   w_next = LD_WRITE;
      end
      LD_WRITE: begin
        Ext_MemWrite = 1'b1;
        w_next = (r_words_left == 16'd1) ? LD_DONE : LD_DATA;
      end
      // A reload sync byte pulls the CPU back into reset in its own rx_valid cycle.
      LD_DONE: begin
        cpu_reset = w_is_sync;
        if (w_is_sync) w_next = LD_LEN0;
      end
      LD_ERR:  if (w_is_sync) w_next = LD_LEN0;
      default: w_next = LD_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_lo     <= '0;
      r_words_left <= '0;
      r_word       <= '0;
      r_idx        <= '0;
      r_adr        <= BASE_ADDR;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        LD_SYNC, LD_DONE, LD_ERR: begin
          if (w_is_sync) begin
            r_adr  <= BASE_ADDR;
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        LD_LEN0: if (w_rx_valid) r_len_lo <= w_rx_byte;
        LD_LEN1: begin
          if (w_rx_valid) begin
            r_words_left <= w_len;
            r_idx        <= '0;
          end
        end
        LD_DATA: begin
          if (w_rx_valid) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0:    r_word[7:0]   <= w_rx_byte;
              2'd1:    r_word[15:8]  <= w_rx_byte;
              2'd2:    r_word[23:16] <= w_rx_byte;
              default: r_wdata       <= {w_rx_byte, r_word};
            endcase
          end
        end
        LD_WRITE: begin
          r_adr        <= r_adr + 32'd4;
          r_words_left <= r_words_left - 16'd1;
        end
        default: ;
      endcase
      // Flags follow the FSM's entry into its terminal states.
      if (w_next == LD_DONE) r_done <= 1'b1;
      if (w_next == LD_ERR)  r_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pran_uart_loader.sv
// Bench for pran_uart_loader: serial stimulus, expected writes derived from the
// word lists sent (word i of a load lands at BASE + 4*i, little-endian).
module tb_pran_uart_loader;

  localparam int unsigned CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        load_done;
  logic        load_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_data_q[$];
  logic [31:0] wr_adr_q[$];
  bit          wr_lat_q[$];
  int          rxv_count = 0;
  int          ferr_count = 0;
  logic        rxv_cpu_reset = 1'b0;
  logic        prev_rxv = 1'b0;

  always #5 clk = ~clk;

  pran_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .uart_rx       (uart_rx),
    .cpu_reset     (cpu_reset),
    .Ext_MemWrite  (Ext_MemWrite),
    .Ext_WriteData (Ext_WriteData),
    .Ext_DataAdr   (Ext_DataAdr),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  // Observed write log; receiver strobes are used only as timing references.
  always @(negedge clk) begin
    if (Ext_MemWrite === 1'b1) begin
      wr_data_q.push_back(Ext_WriteData);
      wr_adr_q.push_back(Ext_DataAdr);
      wr_lat_q.push_back(prev_rxv);
    end
    if (dut.w_rx_valid === 1'b1) begin
      rxv_count++;
      rxv_cpu_reset = cpu_reset;
    end
    if (dut.w_frame_err === 1'b1) ferr_count++;
    prev_rxv = dut.w_rx_valid;
  end

  task automatic clear_log();
    wr_data_q.delete();
    wr_adr_q.delete();
    wr_lat_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cpu_reset !== 1'b1 || Ext_MemWrite !== 1'b0 || Ext_DataAdr !== BASE ||
          load_done !== 1'b0 || load_err !== 1'b0 || Ext_WriteData !== 32'h0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] seq [0:10];
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    clear_log();
    send_byte(junk_byte(), 1'b1);
    tests++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL sync_junk: cpu_reset=%b load_done=%b, required 1/0", cpu_reset, load_done);
    end
    for (int i = 0; i < 11; i++) send_byte(seq[i], 1'b1);
    tests++;
    if (wr_data_q.size() !== 2) begin
      fails++;
      $display("FAIL basic_count: got %0d writes, required 2", wr_data_q.size());
    end else begin
      tests++;
      if (wr_data_q[0] !== 32'h0050_0113 || wr_adr_q[0] !== 32'h0) begin
        fails++;
        $display("FAIL basic_w0: got %h@%h, required 00500113@00000000", wr_data_q[0], wr_adr_q[0]);
      end
      tests++;
      if (wr_data_q[1] !== 32'h00C0_0193 || wr_adr_q[1] !== 32'h4) begin
        fails++;
        $display("FAIL basic_w1: got %h@%h, required 00c00193@00000004", wr_data_q[1], wr_adr_q[1]);
      end
      tests++;
      if (wr_lat_q[0] !== 1'b1 || wr_lat_q[1] !== 1'b1) begin
        fails++;
        $display("FAIL basic_latency: strobe after rx_valid = %b/%b, required 1/1", wr_lat_q[0], wr_lat_q[1]);
      end
    end
    tests++;
    if (cpu_reset !== 1'b0 || load_done !== 1'b1 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: cpu_reset=%b done=%b err=%b, required 0/1/0", cpu_reset, load_done, load_err);
    end
    tests++;
    if (Ext_WriteData !== 32'h00C0_0193 || Ext_DataAdr !== 32'h8) begin
      fails++;
      $display("FAIL basic_hold: data=%h adr=%h, required 00c00193/00000008", Ext_WriteData, Ext_DataAdr);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    tests++;
    if (wr_data_q.size() !== 0 || cpu_reset !== 1'b0 || load_done !== 1'b1 || Ext_DataAdr !== BASE) begin
      fails++;
      $display("FAIL zero_len: writes=%0d cpu_reset=%b done=%b adr=%h, required 0/0/1/%h",
               wr_data_q.size(), cpu_reset, load_done, Ext_DataAdr, BASE);
    end
  endtask

  task automatic test_oversize();
    logic [31:0] w;
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'(MAXW + 1), 1'b1);
    send_byte(8'h00, 1'b1);
    tests++;
    if (load_err !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0 || wr_data_q.size() !== 0) begin
      fails++;
      $display("FAIL oversize: err=%b cpu_reset=%b done=%b writes=%0d, required 1/1/0/0",
               load_err, cpu_reset, load_done, wr_data_q.size());
    end
    w = $urandom;
    send_byte(8'hA5, 1'b1);
    tests++;
    if (load_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: load_err=%b, required 0", load_err);
    end
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(w);
    tests++;
    if (wr_data_q.size() !== 1 || load_done !== 1'b1 || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL recover: writes=%0d done=%b cpu_reset=%b, required 1/1/0", wr_data_q.size(), load_done, cpu_reset);
    end else begin
      tests++;
      if (wr_data_q[0] !== w || wr_adr_q[0] !== BASE) begin
        fails++;
        $display("FAIL recover_word: got %h@%h, required %h@%h", wr_data_q[0], wr_adr_q[0], w, BASE);
      end
    end
  endtask

  task automatic test_random_loads();
    logic [31:0] words[$];
    int nw;
    for (int l = 0; l < 4; l++) begin
      nw = (l == 3) ? int'(MAXW) : int'($urandom_range(1, 6));
      words.delete();
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      clear_log();
      send_byte(junk_byte(), 1'b1);
      tests++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
        fails++;
        $display("FAIL done_junk: done=%b cpu_reset=%b, required 1/0", load_done, cpu_reset);
      end
      send_byte(8'hA5, 1'b1);
      send_byte(nw[7:0], 1'b1);
      send_byte(nw[15:8], 1'b1);
      for (int i = 0; i < nw; i++) send_word(words[i]);
      tests++;
      if (wr_data_q.size() !== nw) begin
        fails++;
        $display("FAIL rand_count: got %0d writes, required %0d", wr_data_q.size(), nw);
      end
      for (int i = 0; i < nw && i < wr_data_q.size(); i++) begin
        tests++;
        if (wr_data_q[i] !== words[i] || wr_adr_q[i] !== BASE + 32'(4 * i) || wr_lat_q[i] !== 1'b1) begin
          fails++;
          $display("FAIL rand_word%0d: got %h@%h lat=%b, required %h@%h lat=1",
                   i, wr_data_q[i], wr_adr_q[i], wr_lat_q[i], words[i], BASE + 32'(4 * i));
        end
      end
      tests++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0 || Ext_DataAdr !== BASE + 32'(4 * nw)) begin
        fails++;
        $display("FAIL rand_done: done=%b cpu_reset=%b adr=%h, required 1/0/%h",
                 load_done, cpu_reset, Ext_DataAdr, BASE + 32'(4 * nw));
      end
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] w;
    int fe0;
    clear_log();
    fe0 = ferr_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    tests++;
    if (load_err !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0 ||
        wr_data_q.size() !== 0 || ferr_count !== fe0 + 1) begin
      fails++;
      $display("FAIL frame_err: err=%b cpu_reset=%b done=%b writes=%0d ferr=%0d, required 1/1/0/0/%0d",
               load_err, cpu_reset, load_done, wr_data_q.size(), ferr_count, fe0 + 1);
    end
    w = $urandom;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(w);
    tests++;
    if (wr_data_q.size() !== 1 || load_err !== 1'b0 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL ferr_recover: writes=%0d err=%b done=%b, required 1/0/1", wr_data_q.size(), load_err, load_done);
    end else begin
      tests++;
      if (wr_data_q[0] !== w || wr_adr_q[0] !== BASE) begin
        fails++;
        $display("FAIL ferr_word: got %h@%h, required %h@%h", wr_data_q[0], wr_adr_q[0], w, BASE);
      end
    end
  endtask

  task automatic test_glitch();
    int rv0;
    int fe0;
    rv0 = rxv_count;
    fe0 = ferr_count;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (15 * CPB) @(negedge clk);
    tests++;
    if (rxv_count !== rv0 || ferr_count !== fe0 || load_done !== 1'b1 || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL glitch: rx_valid=%0d frame_err=%0d done=%b cpu_reset=%b, required %0d/%0d/1/0",
               rxv_count - rv0, ferr_count - fe0, load_done, cpu_reset, 0, 0);
    end
  endtask

  task automatic test_reload_reset();
    logic [31:0] w1;
    logic [31:0] w2;
    int bad;
    w1 = $urandom;
    w2 = $urandom;
    clear_log();
    tests++;
    if (cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL pre_reload: cpu_reset=%b, required 0", cpu_reset);
    end
    rxv_cpu_reset = 1'b0;
    send_byte(8'hA5, 1'b1);
    tests++;
    if (rxv_cpu_reset !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL reload_sync: cpu_reset@rx_valid=%b after=%b done=%b, required 1/1/0",
               rxv_cpu_reset, cpu_reset, load_done);
    end
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(w1);
    send_byte(w2[7:0], 1'b1);
    send_byte(w2[15:8], 1'b1);
    tests++;
    if (wr_data_q.size() !== 1 || Ext_WriteData !== w1 || Ext_DataAdr !== BASE + 32'd4) begin
      fails++;
      $display("FAIL reload_w0: writes=%0d data=%h adr=%h, required 1/%h/%h",
               wr_data_q.size(), Ext_WriteData, Ext_DataAdr, w1, BASE + 32'd4);
    end
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (cpu_reset !== 1'b1 || Ext_MemWrite !== 1'b0 || Ext_WriteData !== 32'h0 ||
        Ext_DataAdr !== BASE || load_done !== 1'b0 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: cpu_reset=%b we=%b data=%h adr=%h done=%b err=%b, required 1/0/0/%h/0/0",
               cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr, load_done, load_err, BASE);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (cpu_reset !== 1'b1 || Ext_MemWrite !== 1'b0 || load_done !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0 || wr_data_q.size() !== 1) begin
      fails++;
      $display("FAIL post_reset: %0d bad cycles writes=%0d, required 0/1", bad, wr_data_q.size());
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(w2);
    tests++;
    if (wr_data_q.size() !== 2 || load_done !== 1'b1 || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL resume: writes=%0d done=%b cpu_reset=%b, required 2/1/0", wr_data_q.size(), load_done, cpu_reset);
    end else begin
      tests++;
      if (wr_data_q[1] !== w2 || wr_adr_q[1] !== BASE) begin
        fails++;
        $display("FAIL resume_word: got %h@%h, required %h@%h", wr_data_q[1], wr_adr_q[1], w2, BASE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_len();
    test_oversize();
    test_random_loads();
    test_frame_err();
    test_glitch();
    test_reload_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pran_uart_loader.md
Name: pran_uart_loader

Overview:
- Boot-time program loader upstream of the CPU top level.
- Receives a program image over a UART RX line (8N1) and assembles little-endian 32-bit words.
- Drives the top level's external memory write port (Ext_MemWrite/Ext_WriteData/Ext_DataAdr).
- Holds the CPU in reset through its cpu_reset output until the image is complete, then releases it.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 64, maximum accepted word count; larger headers are rejected.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input; idle high; asynchronous to clk.
- cpu_reset  out  1  active-high reset to the CPU top level; also gates its external write path.
- Ext_MemWrite  out  1  one-cycle write strobe per assembled word.
- Ext_WriteData  out  32  assembled word.
- Ext_DataAdr  out  32  byte address of the current word.
- load_done  out  1  high once an image is fully written; cleared when a new load starts.
- load_err  out  1  sticky error flag; cleared when a new sync byte is accepted.

Behaviour:
- Reset (reset=0) values: cpu_reset=1, Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=BASE_ADDR, load_done=0, load_err=0, FSM=SYNC, UART RX=IDLE.
- UART RX:
  - uart_rx passes through a 2-flop synchronizer, which resets to 1.
  - A falling edge starts a frame. The line is re-sampled at CLKS_PER_BIT/2. If it is high, this is a false start: return to IDLE with no output.
  - 8 data bits are then sampled every CLKS_PER_BIT, LSB first. Then the stop bit is sampled.
  - rx_valid pulses for 1 cycle with rx_byte.
  - A stop bit of 0 pulses frame_err instead; no byte is delivered.
- Loader FSM states, advancing only on rx_valid unless noted:
  - SYNC: byte 0xA5 -> LEN0, clear load_err and load_done, Ext_DataAdr=BASE_ADDR. Any other byte is ignored.
  - LEN0: store count[7:0] -> LEN1.
  - LEN1: store count[15:8]. count==0 -> DONE. count>MAX_WORDS -> ERR. Otherwise -> DATA with byte index 0.
  - DATA: byte k (0..3) goes to word[8k+7:8k]. The 4th byte -> WRITE.
  - WRITE (1 cycle, unconditional): Ext_MemWrite=1, Ext_WriteData=assembled word, Ext_DataAdr holds the current address.
    - Next cycle: Ext_DataAdr += 4, words_left -= 1.
    - words_left==0 -> DONE, else -> DATA.
  - DONE: cpu_reset=0, load_done=1. A 0xA5 byte re-asserts cpu_reset=1 in the same cycle as its rx_valid and goes to LEN0 (reload). Other bytes are ignored.
  - ERR: load_err=1, cpu_reset stays 1. A 0xA5 byte -> LEN0. Other bytes are ignored.
- frame_err in any state except SYNC/DONE -> ERR, and the partial word is discarded. In SYNC/DONE, frame_err is ignored.
- Latency: Ext_MemWrite asserts exactly 1 cycle after the rx_valid of the word's 4th byte.
- Ext_DataAdr is stable for the whole WRITE cycle. It changes only on the cycle after a write or on sync acceptance.
- Ext_WriteData holds the last written word between writes.
- cpu_reset is 1 in every state except DONE. The top level therefore sees Ext_MemWrite only while cpu_reset=1.
- Address arithmetic is 32-bit modulo; there is no wrap check, since MAX_WORDS bounds it.
- Reset asserted mid-frame or mid-word returns everything to reset values immediately (asynchronous); the partial word is lost.

Decomposition:
- Shared package pran_loader_pkg:
  - SYNC_BYTE=8'hA5.
  - FSM state encoding (SYNC, LEN0, LEN1, DATA, WRITE, DONE, ERR).
  - UART RX state encoding (IDLE, START, DATA, STOP).
- One sub-module: pran_uart_rx.
  - Inputs: clk, reset, uart_rx.
  - Outputs: rx_valid, rx_byte[7:0], frame_err.
  - Contains the synchronizer and bit counter.
- The loader FSM, word assembler and address counter stay in pran_uart_loader.

Test Plan (CLKS_PER_BIT=4, BASE_ADDR=0):
- Reset release, line idle -> cpu_reset=1, Ext_MemWrite=0, Ext_DataAdr=0, load_done=0 for 200 cycles.
- Send A5 02 00, 13 01 50 00, 93 01 C0 00 -> two Ext_MemWrite pulses:
  - 0x00500113 @0, then 0x00C00193 @4;
  - each pulse 1 cycle after its 4th byte;
  - then cpu_reset=0 and load_done=1.
- Send A5 00 00 -> DONE with no write; cpu_reset=0.
- Send A5 41 00 (65 > MAX_WORDS) -> load_err=1, cpu_reset stays 1. Then A5 01 00 + 1 word -> load_err=0, write @0, DONE.
- Mid-word, send a byte with stop bit=0 -> ERR, no Ext_MemWrite. A 2-cycle low glitch on an idle line -> no rx_valid.
- From DONE, send A5 -> cpu_reset=1 the same cycle as rx_valid. Assert reset mid-byte during a reload -> all outputs return to reset values.
